pid_mac_sequencer: RTL

Time-multiplexed controller that evaluates the servo's incremental PID difference equation, u[n] = u[n-1] + k0·e[n] + k1·e[n-1] + k2·e[n-2], in Q9.7 signed fixed point. It uses one shared multiplier and one truncate-and-saturate stage over three cycles. It sits between the error computation and the PWM duty generator. It takes one sample per `start` strobe and returns one saturated control word with a `valid` pulse.

---
 rtl/pid_seq_pkg.sv | 24 ++
 rtl/mult_round_sat.sv | 35 +++
 rtl/pid_mac_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pid_seq_pkg.sv
// Shared definitions for the PID MAC sequencer: FSM encoding, Q9.7 format and clip limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pid_seq_pkg;

    // Default Q-format: 9 integer bits (sign included) and 7 fractional bits in a 16-bit word
    localparam int W    = 16;
    localparam int ENT  = 9;
    localparam int FRAC = 7;

    // Clip limits for the default word width
    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    // Sequencer states: one per product term, plus idle and the result-publish cycle
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mult_round_sat.sv
// Signed gain x error multiply, reduced from Q18.14 to Q9.7 by truncation toward -inf with clipping.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the operands.
module mult_round_sat #(
    parameter int W    = 16,
    parameter int ENT  = 9,
    parameter int FRAC = 7
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] term_o,
    output logic                clip_o
);

    logic signed [2*W-1:0] prod;
    logic        [ENT:0]   hi_bits;
    logic        [FRAC-2:0] unused_lsbs;

    // Sign-extend both operands to full product width so the product is exact
    assign prod        = $signed({{W{a_i[W-1]}}, a_i}) * $signed({{W{b_i[W-1]}}, b_i});
    // The bits above the kept field plus its sign bit must agree for the value to fit
    assign hi_bits     = prod[2*W-1 -: ENT+1];
    assign unused_lsbs = prod[FRAC-2:0];

    // Keep the Q9.7 window when it fits, otherwise clip to the limit matching the product sign
    always_comb begin
        term_o = prod[W+FRAC-1:FRAC];
        clip_o = 1'b0;
        if (!((&hi_bits) || !(|hi_bits))) begin
            clip_o = 1'b1;
            term_o = prod[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pid_mac_sequencer.sv
// Incremental PID: u[n] = u[n-1] + k0*e[n] + k1*e[n-1] + k2*e[n-2] in Q9.7, one shared multiplier.
// Latency: 4 cycles from accepted start to valid; one sample per 5 cycles at most.
// Backpressure: none; start outside IDLE is dropped (flagged on sticky 'overrun' when PID_OVERRUN_EN is defined).
module pid_mac_sequencer
    import pid_seq_pkg::*;
#(
    parameter int cant_bits = W,
    parameter int ent       = ENT,
    parameter int frac      = FRAC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [cant_bits-1:0] error_in,
    input  logic signed [cant_bits-1:0] k0,
    input  logic signed [cant_bits-1:0] k1,
    input  logic signed [cant_bits-1:0] k2,
    output logic                        busy,
    output logic signed [cant_bits-1:0] u_out,
    output logic                        valid,
    output logic                        sat_flag
`ifdef PID_OVERRUN_EN
    ,
    output logic                        overrun
`endif
);

    localparam logic [cant_bits-1:0] ACC_MAX = {1'b0, {(cant_bits-1){1'b1}}};
    localparam logic [cant_bits-1:0] ACC_MIN = {1'b1, {(cant_bits-1){1'b0}}};

    state_t                      state_q;
    logic signed [cant_bits-1:0] e0_q, e1_q, e2_q;
    logic signed [cant_bits-1:0] acc_q, acc_d;
    logic signed [cant_bits-1:0] u_q;
    logic                        sat_q;
    logic                        busy_q, valid_q, sat_flag_q;

    logic signed [cant_bits-1:0] gain_mux, err_mux, term;
    logic                        term_clip, add_clip;
    logic        [cant_bits:0]   sum_ext;

    // Select the gain/error pair for the term being evaluated this cycle
    always_comb begin
        gain_mux = '0;
        err_mux  = '0;
        case (state_q)
            P0:      begin gain_mux = k0; err_mux = e0_q; end
            P1:      begin gain_mux = k1; err_mux = e1_q; end
            P2:      begin gain_mux = k2; err_mux = e2_q; end
            default: begin gain_mux = '0; err_mux = '0;   end
        endcase
    end

    mult_round_sat #(
        .W    (cant_bits),
        .ENT  (ent),
        .FRAC (frac)
    ) u_mult (
        .a_i    (gain_mux),
        .b_i    (err_mux),
        .term_o (term),
        .clip_o (term_clip)
    );

    // One extra bit of headroom exposes overflow; clip toward the sign of the true sum
    always_comb begin
        sum_ext  = {acc_q[cant_bits-1], acc_q} + {term[cant_bits-1], term};
        add_clip = sum_ext[cant_bits] ^ sum_ext[cant_bits-1];
        acc_d    = sum_ext[cant_bits-1:0];
        if (add_clip) begin
            acc_d = sum_ext[cant_bits] ? ACC_MIN : ACC_MAX;
        end
    end

    // Sequencer: capture on start, accumulate three terms, publish and shift history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            e0_q       <= '0;
            e1_q       <= '0;
            e2_q       <= '0;
            acc_q      <= '0;
            u_q        <= '0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            sat_flag_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        e0_q    <= error_in;
                        acc_q   <= u_q;
                        sat_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= P0;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                P0: begin
                    acc_q   <= acc_d;
                    sat_q   <= sat_q | term_clip | add_clip;
                    state_q <= P1;
                end
                P1: begin
                    acc_q   <= acc_d;
                    sat_q   <= sat_q | term_clip | add_clip;
                    state_q <= P2;
                end
                P2: begin
                    acc_q   <= acc_d;
                    sat_q   <= sat_q | term_clip | add_clip;
                    state_q <= DONE;
                end
                DONE: begin
                    u_q        <= acc_q;
                    valid_q    <= 1'b1;
                    sat_flag_q <= sat_q;
                    e2_q       <= e1_q;
                    e1_q       <= e0_q;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef PID_OVERRUN_EN
    logic overrun_q;

    // Sticky record of any start that arrived while a sample was in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (start && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

    assign busy     = busy_q;
    assign u_out    = u_q;
    assign valid    = valid_q;
    assign sat_flag = sat_flag_q;

endmodule
